// File: rtl/mcm_share_arbiter.sv
// mcm_share_arbiter
// Time-shares one multiple-constant-multiplication block (x11 / x9 outputs)
// among NREQ requesters. Each cycle at most one request is granted in
// round-robin order. The requester ID travels beside the operand through a
// tag pipe that matches the block latency. Results land in a response FIFO.
// A credit count reserves a FIFO slot for every operation in flight, so a
// stalled consumer never causes a product to be dropped.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    per-requester handshake (ready is one-hot or zero)
//   req_x              packed operands, requester i at [i*XW +: XW]
//   mcm_x              operand to the shared block
//   mcm_y11, mcm_y9    shared block results, LAT cycles after mcm_x
//   rsp_valid/ready    response handshake
//   rsp_id, rsp_y11/9  tagged response at the FIFO head
//   busy               tags in flight or FIFO not empty
module mcm_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int XW    = 8,
    parameter int YW    = 12,
    parameter int LAT   = 1,
    parameter int DEPTH = 2,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XW-1:0]   req_x,
    output logic [XW-1:0]        mcm_x,
    input  logic [YW-1:0]        mcm_y11,
    input  logic [YW-1:0]        mcm_y9,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [YW-1:0]        rsp_y11,
    output logic [YW-1:0]        rsp_y9,
    output logic                 busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDW-1:0] rr_q, rr_d;
    logic [LAT-1:0] tag_v_q, tag_v_d;
    logic [IDW-1:0] tag_id_q [LAT];
    logic [IDW-1:0] tag_id_d [LAT];
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [IDW-1:0] mem_id_q  [DEPTH];
    logic [YW-1:0]  mem_y11_q [DEPTH];
    logic [YW-1:0]  mem_y9_q  [DEPTH];

    logic           grant_found, grant, credit_ok, push, pop;
    logic [IDW-1:0] grant_idx;
    int             inflight;

    // Scan starting at rr, wrapping, first valid requester wins.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
    end

    always_comb begin
        inflight = 0;
        for (int l = 0; l < LAT; l++) begin
            inflight = inflight + (tag_v_q[l] ? 1 : 0);
        end
    end

    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign push      = tag_v_q[LAT-1];

    // Every tag in flight owns a FIFO slot; a slot freed by this cycle's
    // pop may be reused immediately.
    assign credit_ok = (int'(count_q) + inflight) < (DEPTH + (pop ? 1 : 0));
    assign grant     = rst_n & grant_found & credit_ok;

    assign req_ready = grant ? (NREQ'(1) << grant_idx) : '0;
    assign mcm_x     = grant ? req_x[int'(grant_idx)*XW +: XW] : '0;

    always_comb begin
        rr_d = rr_q;
        if (grant) begin
            rr_d = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        tag_v_d     = '0;
        tag_v_d[0]  = grant;
        tag_id_d[0] = grant_idx;
        for (int l = 1; l < LAT; l++) begin
            tag_v_d[l]  = tag_v_q[l-1];
            tag_id_d[l] = tag_id_q[l-1];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (int'(wr_ptr_q) == DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (int'(rd_ptr_q) == DEPTH - 1) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q     <= '0;
            tag_v_q  <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int l = 0; l < LAT; l++) begin
                tag_id_q[l] <= '0;
            end
        end else begin
            rr_q     <= rr_d;
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id_q[wr_ptr_q]  <= tag_id_q[LAT-1];
            mem_y11_q[wr_ptr_q] <= mcm_y11;
            mem_y9_q[wr_ptr_q]  <= mcm_y9;
        end
    end

    always @(posedge clk) begin
        if (rst_n && push) begin
            assert (int'(count_q) < DEPTH);
        end
    end

    assign rsp_id  = rsp_valid ? mem_id_q[rd_ptr_q]  : '0;
    assign rsp_y11 = rsp_valid ? mem_y11_q[rd_ptr_q] : '0;
    assign rsp_y9  = rsp_valid ? mem_y9_q[rd_ptr_q]  : '0;
    assign busy    = (inflight != 0) || rsp_valid;

endmodule
